// File: rtl/mips_instr_encoder.sv
// Symbolic instruction request -> 32-bit MIPS word encoder with a sequential imem write port.
// Optional SLL/SRL encoding is enabled by defining ENC_SHIFT_EN.
module mips_instr_encoder #(
    parameter int unsigned       ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_in_last,
    input  logic [4:0]        i_op_sel,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    input  logic [15:0]       i_imm,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_full,
    output logic              o_err,
    output logic [ADDR_W:0]   o_word_count
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone, StFull} state_e;

    // Address of the last slot of a load; accepting into it without in_last exhausts memory.
    localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR - 1'b1;

    state_e              r_state;
    state_e              w_state_d;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_ptr;
    logic [31:0]         r_wdata;
    logic                r_err;
    logic [ADDR_W:0]     r_count;

    logic                w_accept;
    logic                w_restart;
    logic [31:0]         w_word;
    logic                w_illegal;
    logic [31:0]         w_rtype;
    logic [25:0]         w_ifields;

    assign w_accept  = i_in_valid && (r_state == StLoad);
    assign w_restart = i_start && (r_state != StLoad);
    assign w_rtype   = {6'h00, i_rs, i_rt, i_rd, 5'h00, 6'h00};
    assign w_ifields = {i_rs, i_rt, i_imm};

    always_comb begin
        w_word    = 32'h0;
        w_illegal = 1'b0;
        case (i_op_sel)
            5'd0:  w_word = w_rtype | 32'h20;
            5'd1:  w_word = w_rtype | 32'h21;
            5'd2:  w_word = w_rtype | 32'h22;
            5'd3:  w_word = w_rtype | 32'h23;
            5'd4:  w_word = w_rtype | 32'h24;
            5'd5:  w_word = w_rtype | 32'h25;
            5'd6:  w_word = w_rtype | 32'h27;
            5'd7:  w_word = w_rtype | 32'h2A;
            5'd8:  w_word = w_rtype | 32'h2B;
            5'd9:  w_word = {6'h00, i_rs, 15'h0000, 6'h08};
            5'd10: w_word = {6'h08, w_ifields};
            5'd11: w_word = {6'h09, w_ifields};
            5'd12: w_word = {6'h23, w_ifields};
            5'd13: w_word = {6'h2B, w_ifields};
            5'd14: w_word = {6'h04, w_ifields};
            5'd15: w_word = 32'h0;
`ifdef ENC_SHIFT_EN
            5'd16: w_word = {11'h000, i_rt, i_rd, i_imm[4:0], 6'h00};
            5'd17: w_word = {11'h000, i_rt, i_rd, i_imm[4:0], 6'h02};
`endif
            // Illegal requests still consume a slot, written as NOP.
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle, StDone, StFull: begin
                if (i_start) w_state_d = StLoad;
            end
            StLoad: begin
                if (w_accept) begin
                    if (i_in_last)               w_state_d = StDone;
                    else if (r_ptr == LAST_ADDR) w_state_d = StFull;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_ptr   <= BASE_ADDR;
            r_wdata <= 32'h0;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_d;
            r_we    <= w_accept;
            if (w_restart) begin
                r_addr  <= BASE_ADDR;
                r_ptr   <= BASE_ADDR;
                r_err   <= 1'b0;
                r_count <= '0;
            end else begin
                if (r_we) r_count <= r_count + 1'b1;
                if (w_accept) begin
                    r_addr  <= r_ptr;
                    r_ptr   <= r_ptr + 1'b1;
                    r_wdata <= w_word;
                    if (w_illegal) r_err <= 1'b1;
                end
            end
        end
    end

    assign o_in_ready   = (r_state == StLoad);
    assign o_busy       = (r_state == StLoad);
    assign o_done       = (r_state == StDone);
    assign o_full       = (r_state == StFull);
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = r_wdata;
    assign o_err        = r_err;
    assign o_word_count = r_count;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench: encoding vector table, handshake/capacity/reset sequences, random loads
// against a field-arithmetic reference model.
module tb_mips_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        start, valid, last;
    logic        s_start, s_valid, s_last;
    logic [4:0]  op, rs, rt, rd;
    logic [15:0] imm;

    logic        ready, we, busy, done, full, err;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [6:0]  wc;

    logic        s_ready, s_we, s_busy, s_done, s_full, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_wc;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned funct_tab[9];
    int unsigned opc_tab[5];

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    vec_t vecs[16];

    mips_instr_encoder #(.ADDR_W(6), .BASE_ADDR(6'd0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_in_valid(valid), .o_in_ready(ready),
        .i_in_last(last), .i_op_sel(op), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_imm(imm),
        .o_imem_we(we), .o_imem_addr(addr), .o_imem_wdata(wdata), .o_busy(busy), .o_done(done),
        .o_full(full), .o_err(err), .o_word_count(wc)
    );

    // Small memory with a non-zero base so the write address wraps before FULL.
    mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd1)) u_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .i_in_valid(s_valid),
        .o_in_ready(s_ready), .i_in_last(s_last), .i_op_sel(op), .i_rs(rs), .i_rt(rt), .i_rd(rd),
        .i_imm(imm), .o_imem_we(s_we), .o_imem_addr(s_addr), .o_imem_wdata(s_wdata),
        .o_busy(s_busy), .o_done(s_done), .o_full(s_full), .o_err(s_err), .o_word_count(s_wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns {illegal, word}, built from the field positions of the MIPS formats.
    function automatic logic [32:0] model_enc(input int op_i, input logic [4:0] rs_i,
                                              input logic [4:0] rt_i, input logic [4:0] rd_i,
                                              input logic [15:0] imm_i);
        int unsigned w  = 0;
        logic        il = 1'b0;
        int unsigned s  = rs_i;
        int unsigned t  = rt_i;
        int unsigned d  = rd_i;
        int unsigned im = imm_i;
        if (op_i <= 8)                    w = s * 2097152 + t * 65536 + d * 2048 + funct_tab[op_i];
        else if (op_i == 9)               w = s * 2097152 + 8;
        else if (op_i >= 10 && op_i <= 14) w = opc_tab[op_i-10] * 67108864 + s * 2097152
                                              + t * 65536 + im;
        else if (op_i == 15)              w = 0;
`ifdef ENC_SHIFT_EN
        else if (op_i == 16 || op_i == 17) w = t * 65536 + d * 2048 + (im % 32) * 64
                                               + ((op_i == 17) ? 2 : 0);
`endif
        else il = 1'b1;
        return {il, w};
    endfunction

    initial begin
        logic [32:0] m;
        logic        m_loading, m_err, exp_acc;
        logic [5:0]  m_ptr;
        int          sent, cyc;

        funct_tab = '{32'h20, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 32'h27, 32'h2A, 32'h2B};
        opc_tab   = '{32'h08, 32'h09, 32'h23, 32'h2B, 32'h04};

        vecs[0]  = '{5'd0,  5'd1,  5'd2,  5'd3, 16'h0000, 32'h00221820, 1'b0};
        vecs[1]  = '{5'd10, 5'd0,  5'd8, 5'd31, 16'hFFFF, 32'h2008FFFF, 1'b0};
        vecs[2]  = '{5'd12, 5'd29, 5'd9,  5'd0, 16'h0004, 32'h8FA90004, 1'b0};
        vecs[3]  = '{5'd14, 5'd8,  5'd9,  5'd0, 16'hFFFE, 32'h1109FFFE, 1'b0};
        vecs[4]  = '{5'd20, 5'd1,  5'd2,  5'd3, 16'h1234, 32'h00000000, 1'b1};
        vecs[5]  = '{5'd6,  5'd1,  5'd2,  5'd3, 16'h0000, 32'h00221827, 1'b0};
`ifdef ENC_SHIFT_EN
        vecs[6]  = '{5'd16, 5'd7,  5'd4,  5'd5, 16'h0003, 32'h000428C0, 1'b0};
        vecs[7]  = '{5'd17, 5'd0,  5'd4,  5'd5, 16'hFFE2, 32'h00042882, 1'b0};
`else
        vecs[6]  = '{5'd16, 5'd7,  5'd4,  5'd5, 16'h0003, 32'h00000000, 1'b1};
        vecs[7]  = '{5'd17, 5'd0,  5'd4,  5'd5, 16'hFFE2, 32'h00000000, 1'b1};
`endif
        vecs[8]  = '{5'd9,  5'd31, 5'd5,  5'd6, 16'h0000, 32'h03E00008, 1'b0};
        vecs[9]  = '{5'd13, 5'd29, 5'd31, 5'd0, 16'h0008, 32'hAFBF0008, 1'b0};
        vecs[10] = '{5'd15, 5'd1,  5'd2,  5'd3, 16'hFFFF, 32'h00000000, 1'b0};
        vecs[11] = '{5'd8,  5'd5,  5'd6,  5'd7, 16'h0000, 32'h00A6382B, 1'b0};
        vecs[12] = '{5'd31, 5'd5,  5'd6,  5'd7, 16'h0000, 32'h00000000, 1'b1};
        vecs[13] = '{5'd3,  5'd3,  5'd4,  5'd5, 16'h0000, 32'h00642823, 1'b0};
        vecs[14] = '{5'd11, 5'd2,  5'd3,  5'd0, 16'h8000, 32'h24438000, 1'b0};
        vecs[15] = '{5'd7,  5'd0,  5'd0,  5'd0, 16'h0000, 32'h0000002A, 1'b0};

        rst_n = 1'b0; start = 0; valid = 0; last = 0; s_start = 0; s_valid = 0; s_last = 0;
        op = 0; rs = 0; rt = 0; rd = 0; imm = 0;

        // Reset state
        #12;
        chk("rst ready", ready, 0);  chk("rst we", we, 0);      chk("rst busy", busy, 0);
        chk("rst done", done, 0);    chk("rst full", full, 0);  chk("rst err", err, 0);
        chk("rst addr", addr, 0);    chk("rst wdata", wdata, 0); chk("rst wc", wc, 0);
        chk("rst small addr", s_addr, 1);
        rst_n = 1'b1;
        tick();
        chk("idle ready", ready, 0);

        // Table: one single-word load per vector
        for (int i = 0; i < 16; i++) begin
            do_start();
            chk($sformatf("v%0d busy", i), busy, 1);
            chk($sformatf("v%0d err clr", i), err, 0);
            op = vecs[i].op; rs = vecs[i].rs; rt = vecs[i].rt; rd = vecs[i].rd; imm = vecs[i].imm;
            valid = 1; last = 1;
            tick();
            valid = 0; last = 0;
            chk($sformatf("v%0d we", i), we, 1);
            chk($sformatf("v%0d addr", i), addr, 0);
            chk($sformatf("v%0d wdata", i), wdata, vecs[i].word);
            chk($sformatf("v%0d err", i), err, vecs[i].err);
            chk($sformatf("v%0d done", i), done, 1);
            tick();
            chk($sformatf("v%0d we off", i), we, 0);
            chk($sformatf("v%0d wc", i), wc, 1);
        end

        // Back-to-back three-word program
        do_start();
        valid = 1;
        for (int k = 0; k < 3; k++) begin
            op = vecs[k+1].op; rs = vecs[k+1].rs; rt = vecs[k+1].rt; rd = vecs[k+1].rd;
            imm = vecs[k+1].imm; last = (k == 2);
            tick();
            chk($sformatf("b2b%0d we", k), we, 1);
            chk($sformatf("b2b%0d addr", k), addr, k);
            chk($sformatf("b2b%0d wdata", k), wdata, vecs[k+1].word);
        end
        valid = 0; last = 0;
        chk("b2b done", done, 1);
        tick();
        tick();
        chk("b2b wc", wc, 3);

        // Small memory: exhaust without in_last, 5th request held off, wrap past top
        op = 0; rs = 1; rt = 2; rd = 3; imm = 0;
        s_start = 1; tick(); s_start = 0;
        s_valid = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("full%0d we", k), s_we, 1);
            chk($sformatf("full%0d addr", k), s_addr, (k + 1) % 4);
            chk($sformatf("full%0d wdata", k), s_wdata, 32'h00221820);
        end
        chk("full flag", s_full, 1);
        chk("full ready", s_ready, 0);
        tick();
        chk("full 5th held", s_we, 0);
        tick();
        chk("full 5th held2", s_we, 0);
        chk("full wc", s_wc, 4);
        s_valid = 0;

        // Small memory: in_last on the last slot -> DONE, not FULL
        s_start = 1; tick(); s_start = 0;
        chk("last busy", s_busy, 1);
        s_valid = 1;
        for (int k = 0; k < 4; k++) begin
            s_last = (k == 3);
            tick();
        end
        s_valid = 0; s_last = 0;
        chk("last addr", s_addr, 0);
        chk("last done", s_done, 1);
        chk("last full", s_full, 0);
        tick();
        chk("last wc", s_wc, 4);

        // Reset before an accept registers: no write pulse
        do_start();
        op = 0; valid = 1;
        #3 rst_n = 0;
        @(posedge clk); #1;
        valid = 0;
        chk("rstacc we", we, 0);
        chk("rstacc busy", busy, 0);
        chk("rstacc wc", wc, 0);
        #2 rst_n = 1;
        tick();
        chk("rstacc we2", we, 0);
        chk("rstacc idle", ready, 0);

        // Reset while a write strobe is high: dropped immediately
        do_start();
        valid = 1;
        tick();
        valid = 0;
        chk("rstw we before", we, 1);
        #2 rst_n = 0;
        #1;
        chk("rstw we", we, 0);
        chk("rstw busy", busy, 0);
        chk("rstw wc", wc, 0);
        #1 rst_n = 1;
        tick();

        // start held during LOAD is ignored
        start = 1;
        tick();
        valid = 1;
        for (int k = 0; k < 4; k++) begin
            last = (k == 3);
            if (k == 3) start = 0;
            tick();
            chk($sformatf("hold%0d addr", k), addr, k);
            chk($sformatf("hold%0d we", k), we, 1);
        end
        valid = 0; last = 0;
        chk("hold done", done, 1);
        tick();
        chk("hold wc", wc, 4);

        // Random loads vs reference model
        for (int r = 0; r < 3; r++) begin
            do_start();
            m_loading = 1; m_err = 0; m_ptr = 0; sent = 0; cyc = 0;
            while (sent < 40 && cyc < 400) begin
                valid = ($urandom_range(3) != 0);
                op  = 5'($urandom_range(31));
                rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
                imm = 16'($urandom);
                last = valid && (sent == 39);
                chk("rnd ready", ready, m_loading);
                exp_acc = valid && m_loading;
                m = model_enc(int'(op), rs, rt, rd, imm);
                tick();
                if (exp_acc) begin
                    m_err = m_err | m[32];
                    chk("rnd we", we, 1);
                    chk("rnd addr", addr, m_ptr);
                    chk("rnd wdata", wdata, m[31:0]);
                    chk("rnd err", err, m_err);
                    m_ptr++;
                    sent++;
                    if (last) m_loading = 0;
                end else begin
                    chk("rnd we idle", we, 0);
                end
                cyc++;
            end
            valid = 0; last = 0;
            tick();
            chk("rnd wc", wc, 40);
            chk("rnd done", done, 1);
            chk("rnd err final", err, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
